// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and serial adder state type
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// rtl/bcd_serial_adder_if.sv - operand/result handshake bundle for the serial BCD adder
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  invalid;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, invalid
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, invalid
  );

endinterface

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - one decimal digit add with carry in/out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] da,
  input  logic [3:0] db,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;
  logic [4:0] t_adj;

  // Invalid digits go through the same correction; the low nibble wraps on purpose.
  always_comb begin
    t     = {1'b0, da} + {1'b0, db} + {4'b0, ci};
    t_adj = t + {1'b0, BCD_ADJ};
    if (t > {1'b0, BCD_MAX}) begin
      s  = t_adj[3:0];
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - multi-digit packed BCD adder, one digit per clock, LSD first
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS + 1);

  bcd_state_e     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           invalid_q, invalid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [3:0]     da, db, ds;
  logic           dco;
  logic           in_invalid;

  bcd_digit_add u_digit (
    .da (da),
    .db (db),
    .ci (carry_q),
    .s  (ds),
    .co (dco)
  );

  always_comb begin
    da = 4'd0;
    db = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        da = a_q[4*i +: 4];
        db = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > BCD_MAX || bus.b[4*i +: 4] > BCD_MAX) begin
        in_invalid = 1'b1;
      end
    end
  end

  // idx runs 0..DIGITS; the idx==DIGITS cycle publishes cout and raises done.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          idx_d     = '0;
          a_d       = bus.a;
          b_d       = bus.b;
          carry_d   = bus.cin;
          sum_d     = '0;
          cout_d    = 1'b0;
          invalid_d = in_invalid;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        if (idx_q == IW'(DIGITS)) begin
          state_d = DONE;
          cout_d  = carry_q;
          done_d  = 1'b1;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
              sum_d[4*i +: 4] = ds;
            end
          end
          carry_d = dco;
          idx_d   = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.invalid = invalid_q;

endmodule
